// File: rtl/ir_fetch.sv
// Instruction fetch front end: credit-limited in-order fetch into a 2-entry
// {word, pc} buffer, with redirect flush and stale-response dropping.
module ir_fetch #(
  parameter int                  IR_WIDTH = 32,
  parameter logic [IR_WIDTH-1:0] RESET_PC = IR_WIDTH'(32'h0000_0000)
) (
  input  logic                clk,
  input  logic                rst,
  output logic                imem_req_valid,
  input  logic                imem_req_ready,
  output logic [IR_WIDTH-1:0] imem_addr,
  input  logic                imem_rsp_valid,
  input  logic [IR_WIDTH-1:0] imem_rsp_data,
  input  logic                redirect_valid,
  input  logic [IR_WIDTH-1:0] redirect_pc,
  input  logic                stall,
  output logic [IR_WIDTH-1:0] ir,
  output logic [IR_WIDTH-1:0] ir_pc,
  output logic                ir_valid
);

  typedef struct packed {
    logic [IR_WIDTH-1:0] word;
    logic [IR_WIDTH-1:0] pc;
  } entry_t;

  localparam logic [IR_WIDTH-1:0] ALIGN_MASK = ~IR_WIDTH'(3);
  localparam logic [IR_WIDTH-1:0] PC_INIT    = RESET_PC & ALIGN_MASK;
  localparam logic [IR_WIDTH-1:0] STEP       = IR_WIDTH'(4);
  localparam logic [IR_WIDTH-1:0] NOP        = IR_WIDTH'(32'h0000_0013);

  logic [IR_WIDTH-1:0] pc, rsp_pc, redir_pc;
  entry_t              buf_q [2];
  logic                wr_ptr, rd_ptr;
  logic [1:0]          count, inflight, drop, inflight_nxt;
  logic                accept, rsp_dec, push, pop;

  // Credit covers both outstanding requests and buffered words, so a
  // returning response always has a slot, even one that is later dropped.
  assign imem_req_valid = !rst && !redirect_valid &&
                          (({1'b0, inflight} + {1'b0, count}) < 3'd2);
  assign accept         = imem_req_valid && imem_req_ready;
  assign imem_addr      = pc;
  assign redir_pc       = redirect_pc & ALIGN_MASK;

  assign rsp_dec      = imem_rsp_valid && (inflight != 2'd0);
  assign inflight_nxt = inflight + {1'b0, accept} - {1'b0, rsp_dec};
  assign push         = imem_rsp_valid && (drop == 2'd0) && !redirect_valid;
  assign pop          = ir_valid && !stall && !redirect_valid;

  assign ir_valid = (count != 2'd0);
  assign ir       = ir_valid ? buf_q[rd_ptr].word : NOP;
  assign ir_pc    = ir_valid ? buf_q[rd_ptr].pc   : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc       <= PC_INIT;
      rsp_pc   <= PC_INIT;
      buf_q[0] <= '0;
      buf_q[1] <= '0;
      wr_ptr   <= 1'b0;
      rd_ptr   <= 1'b0;
      count    <= 2'd0;
      inflight <= 2'd0;
      drop     <= 2'd0;
    end else begin
      inflight <= inflight_nxt;
      if (redirect_valid) begin
        // Everything still outstanding after this cycle belongs to the old stream.
        pc     <= redir_pc;
        rsp_pc <= redir_pc;
        wr_ptr <= 1'b0;
        rd_ptr <= 1'b0;
        count  <= 2'd0;
        drop   <= inflight_nxt;
      end else begin
        if (accept) pc <= pc + STEP;
        if (imem_rsp_valid && (drop != 2'd0)) drop <= drop - 2'd1;
        if (push) begin
          buf_q[wr_ptr] <= '{word: imem_rsp_data, pc: rsp_pc};
          wr_ptr        <= ~wr_ptr;
          rsp_pc        <= rsp_pc + STEP;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
    end
  end

endmodule

// File: tb/tb_ir_fetch.sv
// Directed bench for ir_fetch: in-order 1-cycle memory model with a hold
// input, pop/accept logging, and one task per scenario.
module tb_ir_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req_valid, imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic [31:0] ir, ir_pc;
  logic        ir_valid;
  logic        mem_hold;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef struct { logic [31:0] pc; logic [31:0] w; } pop_t;
  pop_t        pop_q[$];
  logic [31:0] acc_q[$];
  logic [31:0] mq[$];

  ir_fetch dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_addr(imem_addr), .imem_rsp_valid(imem_rsp_valid),
    .imem_rsp_data(imem_rsp_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .stall(stall),
    .ir(ir), .ir_pc(ir_pc), .ir_valid(ir_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  // Memory: answers in request order, one cycle after accept unless held.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      mq.delete();
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= '0;
    end else begin
      if (imem_req_valid && imem_req_ready) mq.push_back(imem_addr);
      if (!mem_hold && mq.size() != 0) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(mq.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (imem_req_valid && imem_req_ready) acc_q.push_back(imem_addr);
      if (ir_valid && !stall && !redirect_valid) pop_q.push_back('{ir_pc, ir});
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic do_reset();
    rst = 1'b1; redirect_valid = 1'b0;
    step(); step();
    pop_q.delete(); acc_q.delete();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ir_valid: got %b want 0", ir_valid); end
    n_checks++; if (ir !== NOP) begin n_fail++; $display("FAIL rst_ir: got %h want %h", ir, NOP); end
    n_checks++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL rst_ir_pc: got %h want 0", ir_pc); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL rst_addr: got %h want 0", imem_addr); end
    step(); step();
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL rst_held_req_valid: got %b want 0", imem_req_valid); end
    step();
    pop_q.delete(); acc_q.delete();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL first_req_valid: got %b want 1", imem_req_valid); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL first_req_addr: got %h want 0", imem_addr); end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL first_ir_valid: got %b want 0", ir_valid); end
  endtask

  // Continues straight from reset release in test_reset.
  task automatic test_stream();
    step();
    @(negedge clk);
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL stream_c1_valid: got %b want 0", ir_valid); end
    n_checks++; if (imem_addr !== 32'h4) begin n_fail++; $display("FAIL stream_c1_addr: got %h want 4", imem_addr); end
    step();
    @(negedge clk);
    n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL stream_c2_valid: got %b want 1", ir_valid); end
    n_checks++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL stream_c2_pc: got %h want 0", ir_pc); end
    n_checks++; if (ir !== mem_word(32'h0)) begin n_fail++; $display("FAIL stream_c2_ir: got %h want %h", ir, mem_word(32'h0)); end
    repeat (12) step();
    n_checks++; if (pop_q.size() < 4) begin n_fail++; $display("FAIL stream_pop_count: got %0d want >=4", pop_q.size()); end
    n_checks++; if (acc_q.size() < 4) begin n_fail++; $display("FAIL stream_acc_count: got %0d want >=4", acc_q.size()); end
    for (int i = 0; i < 4; i++) begin
      if (i < pop_q.size()) begin
        n_checks++; if (pop_q[i].pc !== 32'(4*i)) begin n_fail++; $display("FAIL stream_pop_pc[%0d]: got %h want %h", i, pop_q[i].pc, 32'(4*i)); end
        n_checks++; if (pop_q[i].w !== mem_word(32'(4*i))) begin n_fail++; $display("FAIL stream_pop_w[%0d]: got %h want %h", i, pop_q[i].w, mem_word(32'(4*i))); end
      end
      if (i < acc_q.size()) begin
        n_checks++; if (acc_q[i] !== 32'(4*i)) begin n_fail++; $display("FAIL stream_acc[%0d]: got %h want %h", i, acc_q[i], 32'(4*i)); end
      end
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    do_reset();
    repeat (10) step();
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL stall_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL stall_ir_valid: got %b want 1", ir_valid); end
    n_checks++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL stall_ir_pc: got %h want 0", ir_pc); end
    n_checks++; if (imem_addr !== 32'h8) begin n_fail++; $display("FAIL stall_addr: got %h want 8", imem_addr); end
    step();
    n_checks++; if (acc_q.size() !== 2) begin n_fail++; $display("FAIL stall_acc_count: got %0d want 2", acc_q.size()); end
    stall = 1'b0;
    repeat (8) step();
    n_checks++; if (pop_q.size() < 3) begin n_fail++; $display("FAIL stall_pop_count: got %0d want >=3", pop_q.size()); end
    for (int i = 0; i < 3; i++) begin
      if (i < pop_q.size()) begin
        n_checks++; if (pop_q[i].pc !== 32'(4*i)) begin n_fail++; $display("FAIL stall_pop_pc[%0d]: got %h want %h", i, pop_q[i].pc, 32'(4*i)); end
        n_checks++; if (pop_q[i].w !== mem_word(32'(4*i))) begin n_fail++; $display("FAIL stall_pop_w[%0d]: got %h want %h", i, pop_q[i].w, mem_word(32'(4*i))); end
      end
    end
  endtask

  task automatic test_redirect();
    stall = 1'b0; mem_hold = 1'b1;
    do_reset();
    step(); step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0103;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL redir_req_valid: got %b want 0", imem_req_valid); end
    step();
    redirect_valid = 1'b0; mem_hold = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_addr !== 32'h100) begin n_fail++; $display("FAIL redir_addr: got %h want 100", imem_addr); end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL redir_ir_valid: got %b want 0", ir_valid); end
    repeat (10) step();
    n_checks++; if (pop_q.size() < 1) begin n_fail++; $display("FAIL redir_pop_count: got %0d want >=1", pop_q.size()); end
    if (pop_q.size() >= 1) begin
      n_checks++; if (pop_q[0].pc !== 32'h100) begin n_fail++; $display("FAIL redir_pop_pc: got %h want 100", pop_q[0].pc); end
      n_checks++; if (pop_q[0].w !== mem_word(32'h100)) begin n_fail++; $display("FAIL redir_pop_w: got %h want %h", pop_q[0].w, mem_word(32'h100)); end
    end
  endtask

  task automatic test_redirect_collide();
    stall = 1'b0; mem_hold = 1'b0;
    do_reset();
    step(); step();
    redirect_valid = 1'b1; redirect_pc = 32'h0000_0200;
    @(negedge clk);
    n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL coll_pre_ir_valid: got %b want 1", ir_valid); end
    n_checks++; if (imem_rsp_valid !== 1'b1) begin n_fail++; $display("FAIL coll_pre_rsp_valid: got %b want 1", imem_rsp_valid); end
    step();
    redirect_valid = 1'b0;
    @(negedge clk);
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL coll_ir_valid: got %b want 0", ir_valid); end
    n_checks++; if (ir !== NOP) begin n_fail++; $display("FAIL coll_ir: got %h want %h", ir, NOP); end
    n_checks++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL coll_ir_pc: got %h want 0", ir_pc); end
    n_checks++; if (imem_addr !== 32'h200) begin n_fail++; $display("FAIL coll_addr: got %h want 200", imem_addr); end
    n_checks++; if (imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL coll_req_valid: got %b want 1", imem_req_valid); end
    repeat (8) step();
    n_checks++; if (pop_q.size() < 2) begin n_fail++; $display("FAIL coll_pop_count: got %0d want >=2", pop_q.size()); end
    if (pop_q.size() >= 2) begin
      n_checks++; if (pop_q[0].pc !== 32'h200) begin n_fail++; $display("FAIL coll_pop_pc0: got %h want 200", pop_q[0].pc); end
      n_checks++; if (pop_q[0].w !== mem_word(32'h200)) begin n_fail++; $display("FAIL coll_pop_w0: got %h want %h", pop_q[0].w, mem_word(32'h200)); end
      n_checks++; if (pop_q[1].pc !== 32'h204) begin n_fail++; $display("FAIL coll_pop_pc1: got %h want 204", pop_q[1].pc); end
    end
  endtask

  task automatic test_ready_wrap();
    stall = 1'b0; imem_req_ready = 1'b0;
    do_reset();
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFFE;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_checks++; if (imem_addr !== 32'hFFFF_FFFC || imem_req_valid !== 1'b1) begin n_fail++; $display("FAIL notready_hold[%0d]: got addr %h valid %b want FFFFFFFC 1", i, imem_addr, imem_req_valid); end
      step();
    end
    imem_req_ready = 1'b1;
    step();
    @(negedge clk);
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
    repeat (8) step();
    n_checks++; if (pop_q.size() < 2) begin n_fail++; $display("FAIL wrap_pop_count: got %0d want >=2", pop_q.size()); end
    if (pop_q.size() >= 2) begin
      n_checks++; if (pop_q[0].pc !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_pop_pc0: got %h want FFFFFFFC", pop_q[0].pc); end
      n_checks++; if (pop_q[0].w !== mem_word(32'hFFFF_FFFC)) begin n_fail++; $display("FAIL wrap_pop_w0: got %h want %h", pop_q[0].w, mem_word(32'hFFFF_FFFC)); end
      n_checks++; if (pop_q[1].pc !== 32'h0) begin n_fail++; $display("FAIL wrap_pop_pc1: got %h want 0", pop_q[1].pc); end
    end
  endtask

  task automatic test_reset_midstream();
    stall = 1'b0; mem_hold = 1'b0; imem_req_ready = 1'b1;
    do_reset();
    repeat (5) step();
    n_checks++; if (ir_valid !== 1'b1) begin n_fail++; $display("FAIL mid_pre_ir_valid: got %b want 1", ir_valid); end
    rst = 1'b1;
    #1;
    n_checks++; if (imem_req_valid !== 1'b0) begin n_fail++; $display("FAIL mid_req_valid: got %b want 0", imem_req_valid); end
    n_checks++; if (ir_valid !== 1'b0) begin n_fail++; $display("FAIL mid_ir_valid: got %b want 0", ir_valid); end
    n_checks++; if (ir !== NOP) begin n_fail++; $display("FAIL mid_ir: got %h want %h", ir, NOP); end
    n_checks++; if (ir_pc !== 32'h0) begin n_fail++; $display("FAIL mid_ir_pc: got %h want 0", ir_pc); end
    n_checks++; if (imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_addr: got %h want 0", imem_addr); end
    step();
    pop_q.delete(); acc_q.delete();
    rst = 1'b0;
    @(negedge clk);
    n_checks++; if (imem_req_valid !== 1'b1 || imem_addr !== 32'h0) begin n_fail++; $display("FAIL mid_restart: got valid %b addr %h want 1 0", imem_req_valid, imem_addr); end
    repeat (6) step();
    n_checks++; if (pop_q.size() < 1) begin n_fail++; $display("FAIL mid_pop_count: got %0d want >=1", pop_q.size()); end
    if (pop_q.size() >= 1) begin
      n_checks++; if (pop_q[0].pc !== 32'h0 || pop_q[0].w !== mem_word(32'h0)) begin n_fail++; $display("FAIL mid_pop0: got %h/%h want 0/%h", pop_q[0].pc, pop_q[0].w, mem_word(32'h0)); end
    end
  endtask

  initial begin
    rst = 1'b1; imem_req_ready = 1'b1; redirect_valid = 1'b0;
    redirect_pc = '0; stall = 1'b0; mem_hold = 1'b0;
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_ready_wrap();
    test_reset_midstream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ir_fetch.md
IR_FETCH -- requirements
Module: ir_fetch

Interface
REQ-001 SHALL have parameter IR_WIDTH, default 32: instruction and address width.
REQ-002 SHALL have parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-003 SHALL have port clk  input  1: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous and active-high.
REQ-005 SHALL have port imem_req_valid  output  1: fetch request valid.
REQ-006 SHALL have port imem_req_ready  input  1: memory accepts the request this cycle.
REQ-007 SHALL have port imem_addr  output  IR_WIDTH: fetch byte address, bits [1:0] always 0.
REQ-008 SHALL have port imem_rsp_valid  input  1: instruction word returned, in request order.
REQ-009 SHALL have port imem_rsp_data  input  IR_WIDTH: returned instruction word.
REQ-010 SHALL have port redirect_valid  input  1: branch/jump taken, restart the fetch stream.
REQ-011 SHALL have port redirect_pc  input  IR_WIDTH: new fetch address; bits [1:0] ignored and treated as 0.
REQ-012 SHALL have port stall  input  1: decoder not accepting an instruction this cycle.
REQ-013 SHALL have port ir  output  IR_WIDTH: instruction presented to the decoder.
REQ-014 SHALL have port ir_pc  output  IR_WIDTH: address of ir.
REQ-015 SHALL have port ir_valid  output  1: ir/ir_pc hold a real fetched instruction.

Function
REQ-016 SHALL keep a fetch PC; a request is accepted when imem_req_valid and imem_req_ready are both 1, and the fetch PC then advances by 4, wrapping modulo 2^IR_WIDTH.
REQ-017 SHALL drive imem_addr from the fetch PC in every cycle.
REQ-018 SHALL keep a 2-entry in-order buffer of {word, pc}, plus an in-flight counter (0..2) and a drop counter (0..2).
REQ-019 SHALL assert imem_req_valid only when in-flight + buffer count < 2 and redirect_valid is 0 (credit rule; the buffer never overflows).
REQ-020 SHALL hold imem_addr stable while imem_req_valid=1 and imem_req_ready=0.
REQ-021 SHALL decrement the in-flight counter for every imem_rsp_valid; an accept and a response in the same cycle leave the counter unchanged.
REQ-022 SHALL discard a response when the drop counter is nonzero and decrement the drop counter; otherwise push it with a response PC that starts at RESET_PC or the redirect target and advances by 4 per pushed word.
REQ-023 SHALL show the buffer head on ir/ir_pc with ir_valid=1; the head pops when ir_valid=1 and stall=0.
REQ-024 SHALL allow a response pushed into an empty buffer to appear on ir in the next cycle, giving minimum latency from request accept to ir_valid of 2 cycles with a 1-cycle memory.
REQ-025 SHALL handle a push and a pop in the same cycle with the count unchanged and order preserved.
REQ-026 SHALL drive ir=32'h0000_0013 (NOP) and ir_pc=0 whenever ir_valid=0.
REQ-027 SHALL, on redirect_valid=1 in a cycle, do all of the following:
- flush the buffer, so ir_valid=0 next cycle and any pop that cycle is ignored;
- discard any response arriving that cycle;
- set the drop counter to the in-flight count remaining after that cycle;
- load the fetch PC and the response PC with {redirect_pc[IR_WIDTH-1:2],2'b00}.
REQ-028 SHALL resume requests in the cycle after a redirect when credit allows.
REQ-029 SHALL apply back-to-back redirects in order, so the last redirect's target is the one fetched.
REQ-030 SHALL make stall affect only popping; fetching continues until credit is exhausted.

Reset
REQ-031 SHALL, while rst=1, immediately set:
- fetch PC and response PC = RESET_PC;
- buffer, in-flight and drop counters = 0;
- imem_req_valid=0, ir_valid=0, ir=32'h13, ir_pc=0.
REQ-032 SHALL discard all traffic after reset asserted mid-operation; memory responses to pre-reset requests are the environment's responsibility to suppress.
REQ-033 SHALL issue the first request, imem_addr=RESET_PC, in the first cycle after rst deasserts.

Verification
REQ-034 Reset release, always-ready 1-cycle memory, stall=0 -> requests at 0x0, 0x4, 0x8...; ir_valid first high 2 cycles after first accept; ir_pc follows 0x0, 0x4, 0x8.
REQ-035 stall held 1 for 10 cycles -> exactly 2 requests outstanding or buffered, imem_req_valid=0; on release 0x0 then 0x4 pop in order, no loss or duplication.
REQ-036 Redirect to 0x103 with 2 requests in flight -> both stale responses dropped; next ir_pc=0x100 carries the word fetched from 0x100.
REQ-037 Redirect in the same cycle as a response and a pop -> response discarded; ir_valid=0 next cycle; no stale pc ever seen on ir_pc.
REQ-038 imem_req_ready=0 for 5 cycles -> imem_addr stable, no PC advance; PC 0xFFFF_FFFC wraps to 0x0 after accept.
REQ-039 rst pulsed mid-stream -> all outputs at reset values that cycle; restart from RESET_PC.
